// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD engine: operand width and controller state encoding.
package gcd_pkg;

    localparam int WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/gcd_engine_if.sv
// Host-side request/response bundle for the GCD engine.
interface gcd_engine_if #(
    parameter int W = gcd_pkg::WIDTH
);

    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] result;
    logic         done;
    logic         busy;

    modport master (output start, A, B, input result, done, busy);
    modport slave  (input start, A, B, output result, done, busy);

endinterface

// File: rtl/gcd_datapath.sv
// Operand/result registers plus the comparator and subtractor used by the GCD controller.
module gcd_datapath
    import gcd_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_sub_x,
    input  logic         i_sub_y,
    input  logic         i_latch_res,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_result,
    output logic         o_x_gt_y,
    output logic         o_x_eq_y,
    output logic         o_x_zero,
    output logic         o_y_zero
);

    logic [W-1:0] r_x;
    logic [W-1:0] r_y;
    logic [W-1:0] r_result;

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x      <= '0;
            r_y      <= '0;
            r_result <= '0;
        end else begin
            if (i_load) begin
                r_x <= i_a;
                r_y <= i_b;
            end else begin
                if (i_sub_x) r_x <= r_x - r_y;
                if (i_sub_y) r_y <= r_y - r_x;
            end
            // With x zero the answer is y; otherwise x covers both y==0 and x==y.
            if (i_latch_res) r_result <= o_x_zero ? r_y : r_x;
        end
    end

    assign o_x_gt_y = (r_x > r_y);
    assign o_x_eq_y = (r_x == r_y);
    assign o_x_zero = (r_x == '0);
    assign o_y_zero = (r_y == '0);
    assign o_result = r_result;

endmodule

// File: rtl/gcd_engine.sv
// GCD engine top: IDLE/CALC/DONE controller steering the subtract-and-compare datapath.
module gcd_engine
    import gcd_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    gcd_engine_if.slave  bus
);

    state_t r_state;
    state_t w_next;
    logic   r_done;
    logic   r_busy;
    logic   w_load;
    logic   w_sub_x;
    logic   w_sub_y;
    logic   w_latch_res;
    logic   w_x_gt_y;
    logic   w_x_eq_y;
    logic   w_x_zero;
    logic   w_y_zero;

    gcd_datapath #(.W(WIDTH)) u_datapath (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_load),
        .i_sub_x     (w_sub_x),
        .i_sub_y     (w_sub_y),
        .i_latch_res (w_latch_res),
        .i_a         (bus.A),
        .i_b         (bus.B),
        .o_result    (bus.result),
        .o_x_gt_y    (w_x_gt_y),
        .o_x_eq_y    (w_x_eq_y),
        .o_x_zero    (w_x_zero),
        .o_y_zero    (w_y_zero)
    );

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_next      = r_state;
        w_load      = 1'b0;
        w_sub_x     = 1'b0;
        w_sub_y     = 1'b0;
        w_latch_res = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_load = 1'b1;
                    w_next = CALC;
                end
            end
            CALC: begin
                if (w_x_zero || w_y_zero || w_x_eq_y) begin
                    w_latch_res = 1'b1;
                    w_next      = DONE;
                end else if (w_x_gt_y) begin
                    w_sub_x = 1'b1;
                end else begin
                    w_sub_y = 1'b1;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // done/busy are registered from the next state so they align exactly with r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (w_next == DONE);
            r_busy  <= (w_next != IDLE);
        end
    end

    assign bus.done = r_done;
    assign bus.busy = r_busy;

endmodule

// File: tb/tb_gcd_engine.sv
// Scoreboard bench for gcd_engine: Euclid-based reference model, decoupled monitor.
module tb_gcd_engine;

    typedef struct {
        int res;
        int lat;
        int acc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   failures;
    int   done_cnt;
    int   prev_res;
    bit   after_done;
    exp_t sb[$];

    gcd_engine_if bus ();

    gcd_engine dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // gcd via Euclid's modulo form; subtraction count is the sum of the quotients,
    // minus one because the final equal-operands step latches instead of subtracting.
    task automatic ref_gcd(input int a, input int b, output int g, output int lat);
        int x;
        int y;
        int t;
        int s;
        if (a == 0 || b == 0) begin
            g   = a + b;
            lat = 1;
        end else begin
            x = a;
            y = b;
            s = 0;
            while (y != 0) begin
                s += x / y;
                t = x % y;
                x = y;
                y = t;
            end
            g   = x;
            lat = s;
        end
    endtask

    task automatic issue(input int a, input int b, input bit push);
        int   n;
        int   g;
        int   lat;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (bus.busy && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) check("idle_wait", int'(bus.busy), 0);
        bus.start = 1'b1;
        bus.A     = a[7:0];
        bus.B     = b[7:0];
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.A     = 8'($urandom);
        bus.B     = 8'($urandom);
        if (push) begin
            ref_gcd(a, b, g, lat);
            e.res = g;
            e.lat = lat;
            e.acc = cyc;
            sb.push_back(e);
        end
        @(negedge clk);
        check("result_hold", int'(bus.result), prev_res);
        if (push) prev_res = g;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            after_done = 1'b0;
        end else begin
            if (after_done) begin
                check("busy_after_done", int'(bus.busy), 0);
                check("done_one_cycle", int'(bus.done), 0);
                after_done = 1'b0;
            end
            if (bus.done) begin
                done_cnt++;
                after_done = 1'b1;
                check("busy_in_done", int'(bus.busy), 1);
                if (sb.size() == 0) begin
                    check("unexpected_done", int'(bus.done), 0);
                end else begin
                    e = sb.pop_front();
                    check("result", int'(bus.result), e.res);
                    check("latency", cyc - e.acc, e.lat);
                end
            end
        end
    end

    initial begin
        #600000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int snap;
        int n;
        checks     = 0;
        failures   = 0;
        done_cnt   = 0;
        prev_res   = 0;
        after_done = 1'b0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.A      = 8'd0;
        bus.B      = 8'd0;
        repeat (3) @(negedge clk);
        check("reset_result", int'(bus.result), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_busy", int'(bus.busy), 0);
        rst_n = 1'b1;

        issue(5, 20, 1'b1);
        issue(30, 7, 1'b1);
        issue(140, 20, 1'b1);
        issue(0, 9, 1'b1);
        issue(9, 0, 1'b1);
        issue(0, 0, 1'b1);
        issue(255, 1, 1'b1);

        // A start pulse mid-job must not disturb the operands in flight.
        issue(100, 75, 1'b1);
        bus.start = 1'b1;
        bus.A     = 8'd12;
        bus.B     = 8'd18;
        @(negedge clk);
        bus.start = 1'b0;
        issue(12, 18, 1'b1);

        // Reset mid-job discards it without a done pulse.
        issue(200, 3, 1'b0);
        repeat (5) @(negedge clk);
        snap  = done_cnt;
        rst_n = 1'b0;
        #1;
        check("midreset_result", int'(bus.result), 0);
        check("midreset_busy", int'(bus.busy), 0);
        check("midreset_done", int'(bus.done), 0);
        prev_res = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        check("no_done_after_reset", done_cnt, snap);
        issue(48, 36, 1'b1);

        for (int i = 0; i < 24; i++) begin
            int a;
            int b;
            if (i % 3 == 0) begin
                a = int'($urandom_range(0, 15));
                b = int'($urandom_range(0, 15));
            end else begin
                a = int'($urandom_range(0, 255));
                b = int'($urandom_range(1, 255));
            end
            issue(a, b, 1'b1);
        end

        n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", sb.size(), 0);
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
